unified_mem_ctrl: RTL
=====================

Name: unified_mem_ctrl

Overview:
Parametrised memory subsystem that replaces the separate instruction and data SRAM instances with one shared single-port word array behind a two-channel arbiter. The instruction-fetch (IM) and data load/store (DM) channels each use a req/gnt handshake. Read data returns after a configurable pipelined latency, with a per-channel rvalid. A starvation guard bounds the wait of the losing channel. The CPU stalls a channel on req && !gnt.

Parameters:
ADDR_W, 16, byte-address width; the word index is addr[ADDR_W-1:2].
DATA_W, 32, data word width; must be a multiple of 8.
DEPTH_WORDS, 16384, number of array words; power of 2, at most 2^(ADDR_W-2).
RD_LAT, 1, cycles from the accepting edge to rvalid; legal range 1..4.
DM_PRIORITY, 1, 1 = DM wins a simultaneous request, 0 = IM wins.
MAX_WAIT, 3, consecutive denied cycles after which the losing channel is forced to win.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
im_req  in  1  IM read request.
im_addr  in  ADDR_W  IM byte address.
im_gnt  out  1  IM request accepted this cycle (combinational).
im_rvalid  out  1  im_rdata valid (registered).
im_rdata  out  DATA_W  IM read data.
dm_req  in  1  DM request.
dm_web  in  1  0 = write, 1 = read (active-low write enable).
dm_bweb  in  DATA_W  per-bit write mask, active-low (0 = write this bit).
dm_addr  in  ADDR_W  DM byte address.
dm_di  in  DATA_W  DM write data.
dm_gnt  out  1  DM request accepted this cycle (combinational).
dm_rvalid  out  1  dm_do valid (registered); pulses for reads only.
dm_do  out  DATA_W  DM read data.
busy  out  1  at least one read is in flight in the return pipeline.

Behaviour:
- Reset (rst = 1 at a rising edge):
  - Clears the return pipeline, both wait counters, and the rdata/do registers.
  - im_rvalid = dm_rvalid = busy = 0, im_rdata = dm_do = 0.
  - Array contents are NOT cleared.
  - While rst = 1, im_gnt = dm_gnt = 0.
  - Reads in flight when reset asserts are dropped and never produce rvalid.
- Acceptance: a channel's request is accepted when req && gnt is high at the rising edge. At most one request is accepted per cycle.
- Grant logic (combinational):
  - Single requester: granted.
  - Both requesting: the winner is the channel whose wait counter equals MAX_WAIT; otherwise the DM_PRIORITY channel.
  - A channel whose counter equals MAX_WAIT always wins, so with MAX_WAIT >= 1 the two counters never reach MAX_WAIT together.
- Wait counters (per channel, saturating at MAX_WAIT):
  - Increment on req && !gnt.
  - Clear on an accept, or when req is low.
- Indexing: word index = addr[ADDR_W-1:2] modulo DEPTH_WORDS (upper bits ignored, wrap-around). addr[1:0] is ignored.
- DM write (dm_web = 0):
  - On the accepting edge, each array bit i with dm_bweb[i] = 0 takes dm_di[i]; bits with dm_bweb[i] = 1 are unchanged.
  - No rvalid is generated.
  - dm_bweb all ones means no change.
- Reads (IM, or DM with dm_web = 1):
  - Fully pipelined: a channel may be accepted on every cycle.
  - The array is read at the accepting edge. A source tag travels through an RD_LAT-deep shift register.
  - Data appears on im_rdata / dm_do with its rvalid exactly RD_LAT cycles after the accepting edge (RD_LAT = 1: the next cycle).
  - rvalid is a 1-cycle pulse per accepted read.
  - rdata/do hold their last value when rvalid = 0.
- Ordering:
  - A read accepted on the cycle after a write to the same word returns the new data.
  - A write and a read are never accepted in the same cycle.
  - Responses are returned in acceptance order.
- busy = OR of the valid bits of the return pipeline.

Test Plan:
- Reset then idle: hold rst 2 cycles, release, no requests -> all gnt/rvalid/busy = 0, im_rdata = dm_do = 0.
- Single IM read, RD_LAT = 1: preload word 5 = 0xDEADBEEF, im_req with im_addr = 0x0014 for 1 cycle -> im_gnt = 1 same cycle; im_rvalid = 1 with im_rdata = 0xDEADBEEF one cycle later, for one cycle only.
- Masked write then read: word 2 = 0x11223344; DM write dm_addr = 0x0008, dm_di = 0xAABBCCDD, dm_bweb = 0xFFFF0000; next cycle DM read of 0x0008 -> dm_do = 0x1122CCDD, and the write produces no dm_rvalid.
- Conflict and starvation, DM_PRIORITY = 1, MAX_WAIT = 3: both req held high continuously.
  - dm_gnt = 1 for cycles 0-2.
  - im_gnt = 1 in cycle 3; dm_gnt = 1 again in cycle 4.
  - The IM-grant pattern repeats every 4th cycle.
- Latency and wrap, RD_LAT = 3, DEPTH_WORDS = 16: back-to-back IM reads of 0x0000 and 0x0040 (both word 0 after wrap) -> two im_rvalid pulses 3 and 4 cycles after the first accept, equal data, busy high throughout.
- Reset mid-flight, RD_LAT = 3: accept a DM read, assert rst on the next edge -> no dm_rvalid ever appears for it; busy = 0 after reset.

Source files
------------

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: one shared single-port word array serving an instruction-fetch
// (IM) channel and a data load/store (DM) channel through a req/gnt arbiter.
// Reads return through an RD_LAT-deep tagged pipeline. A per-channel wait counter
// forces the losing channel to win once it has been denied MAX_WAIT cycles in a row.
module unified_mem_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int RD_LAT      = 1,
    parameter int DM_PRIORITY = 1,
    parameter int MAX_WAIT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              im_req,
    input  logic [ADDR_W-1:0] im_addr,
    output logic              im_gnt,
    output logic              im_rvalid,
    output logic [DATA_W-1:0] im_rdata,
    input  logic              dm_req,
    input  logic              dm_web,
    input  logic [DATA_W-1:0] dm_bweb,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_di,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_do,
    output logic              busy
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    // Intermediate return stages; the rvalid/rdata registers form the final stage.
    localparam int PIPE   = (RD_LAT > 1) ? RD_LAT - 1 : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic {
        SRC_IM = 1'b0,
        SRC_DM = 1'b1
    } src_t;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [WAIT_W-1:0] im_wait;
    logic [WAIT_W-1:0] dm_wait;
    logic              im_starved;
    logic              dm_starved;

    logic [IDX_W-1:0]  im_idx;
    logic [IDX_W-1:0]  dm_idx;
    logic              im_acc;
    logic              dm_acc;
    logic              rd_acc;
    src_t              rd_src;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;

    logic [PIPE-1:0]   pipe_vld;
    src_t [PIPE-1:0]   pipe_src;
    logic [DATA_W-1:0] pipe_data [PIPE];

    logic              ret_vld;
    src_t              ret_src;
    logic [DATA_W-1:0] ret_data;

    logic              unused_addr_bits;

    // Arbitration: a starved channel wins, otherwise the priority channel wins a tie.
    always_comb begin
        im_starved = (im_wait == WAIT_MAX);
        dm_starved = (dm_wait == WAIT_MAX);
        im_gnt     = '0;
        dm_gnt     = '0;
        if (!rst) begin
            if (im_req && dm_req) begin
                if (im_starved) begin
                    im_gnt = '1;
                end else if (dm_starved) begin
                    dm_gnt = '1;
                end else if (DM_PRIORITY != 0) begin
                    dm_gnt = '1;
                end else begin
                    im_gnt = '1;
                end
            end else begin
                im_gnt = im_req;
                dm_gnt = dm_req;
            end
        end
    end

    // Word indexing, accept decode and the array read that enters the return path.
    always_comb begin
        im_idx           = im_addr[IDX_W+1:2];
        dm_idx           = dm_addr[IDX_W+1:2];
        unused_addr_bits = ^{im_addr, dm_addr};
        im_acc           = im_req & im_gnt;
        dm_acc           = dm_req & dm_gnt;
        rd_acc           = im_acc | (dm_acc & dm_web);
        rd_src           = dm_acc ? SRC_DM : SRC_IM;
        rd_idx           = dm_acc ? dm_idx : im_idx;
        rd_data          = mem[rd_idx];
        ret_vld          = rd_acc;
        ret_src          = rd_src;
        ret_data         = rd_data;
        if (RD_LAT > 1) begin
            ret_vld  = pipe_vld[PIPE-1];
            ret_src  = pipe_src[PIPE-1];
            ret_data = pipe_data[PIPE-1];
        end
    end

    // Saturating wait counters: count denied cycles, clear on accept or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            im_wait <= '0;
            dm_wait <= '0;
        end else begin
            if (im_req && !im_gnt) begin
                im_wait <= im_starved ? im_wait : im_wait + 1'b1;
            end else begin
                im_wait <= '0;
            end
            if (dm_req && !dm_gnt) begin
                dm_wait <= dm_starved ? dm_wait : dm_wait + 1'b1;
            end else begin
                dm_wait <= '0;
            end
        end
    end

    // Bit-masked DM write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (dm_acc && !dm_web) begin
            mem[dm_idx] <= (mem[dm_idx] & dm_bweb) | (dm_di & ~dm_bweb);
        end
    end

    // Intermediate return stages carrying valid, source tag and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0]  <= rd_acc;
            pipe_src[0]  <= rd_src;
            pipe_data[0] <= rd_data;
            for (int unsigned i = 1; i < unsigned'(PIPE); i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_src[i]  <= pipe_src[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Final stage: steer the returning word to its channel; data holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            im_rvalid <= '0;
            dm_rvalid <= '0;
            im_rdata  <= '0;
            dm_do     <= '0;
        end else begin
            im_rvalid <= ret_vld && (ret_src == SRC_IM);
            dm_rvalid <= ret_vld && (ret_src == SRC_DM);
            if (ret_vld && (ret_src == SRC_IM)) begin
                im_rdata <= ret_data;
            end
            if (ret_vld && (ret_src == SRC_DM)) begin
                dm_do <= ret_data;
            end
        end
    end

    // With RD_LAT = 1 pipe_vld mirrors the rvalid registers, so the OR stays exact.
    always_comb begin
        busy = im_rvalid | dm_rvalid | (|pipe_vld);
    end

endmodule
